// File: rtl/filter_frame_sequencer_pkg.sv
// Shared types and helpers for the filter frame sequencer.
// Pixel width, FSM encoding and the kernel border helper.
package filter_frame_sequencer_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TOP   = 3'd1,
        S_LPAD  = 3'd2,
        S_DATA  = 3'd3,
        S_RPAD  = 3'd4,
        S_BOT   = 3'd5,
        S_FLUSH = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    function automatic int border(input int k);
        return (k - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_frame_sequencer.sv
// Frame sequencer: wraps a pixel stream in the zero border a KxK filter
// needs, flushes the filter and checks how many output pixels came back.
module filter_frame_sequencer
    import filter_frame_sequencer_pkg::*;
#(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int KERNEL_SIZE = 3,
    parameter int FLUSH       = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             f_valid,
    output logic [PIX_W-1:0] f_data,
    input  logic             f_ovalid,
    output logic             frame_done,
    output logic             count_ok
);

    localparam int B = border(KERNEL_SIZE);
    localparam int D = WIDTH + 2 * B;

    localparam logic [31:0] SIDE_N    = 32'(B);
    localparam logic [31:0] ROWPAD_N  = 32'(B * D);
    localparam logic [31:0] FLUSH_N   = 32'(FLUSH);
    localparam logic [31:0] LAST_COL  = 32'(WIDTH - 1);
    localparam logic [31:0] LAST_ROW  = 32'(HEIGHT - 1);
    localparam logic [31:0] PIX_TOTAL = 32'(WIDTH * HEIGHT);

    // Zero-length phases are skipped by routing around them.
    localparam state_e FIRST_S    = (B > 0) ? S_TOP : S_DATA;
    localparam state_e ROW_S      = (B > 0) ? S_LPAD : S_DATA;
    localparam state_e AFTER_BOT  = (FLUSH > 0) ? S_FLUSH : S_DONE;
    localparam state_e AFTER_ROWS = (B > 0) ? S_BOT : AFTER_BOT;

    state_e state_q, state_d;

    logic [31:0] beat_q, beat_d;
    logic [31:0] col_q, col_d;
    logic [31:0] row_q, row_d;
    logic [31:0] out_cnt_q, out_cnt_d;

    logic count_ok_q, count_ok_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic f_valid_q, f_valid_d;
    logic [PIX_W-1:0] f_data_q, f_data_d;

    logic [31:0] pad_len;
    logic pad_last;
    logic last_row;
    logic col_last;
    logic hs;
    logic start_ok;
    logic row_end;
    logic is_pad;
    state_e pad_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_cnt_q    <= '0;
            count_ok_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            f_valid_q    <= 1'b0;
            f_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_cnt_q    <= out_cnt_d;
            count_ok_q   <= count_ok_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            f_valid_q    <= f_valid_d;
            f_data_q     <= f_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        col_d      = col_q;
        row_d      = row_q;
        out_cnt_d  = out_cnt_q;
        count_ok_d = count_ok_q;
        pad_len    = '0;
        pad_next   = S_IDLE;

        hs       = s_valid && (state_q == S_DATA);
        last_row = (row_q == LAST_ROW);
        col_last = (col_q == LAST_COL);
        // busy_q still covers the done cycle, so a late start is dropped.
        start_ok = start && (state_q == S_IDLE) && !busy_q;

        unique case (state_q)
            S_TOP:   begin pad_len = ROWPAD_N; pad_next = S_LPAD; end
            S_LPAD:  begin pad_len = SIDE_N;   pad_next = S_DATA; end
            S_RPAD:  begin
                pad_len  = SIDE_N;
                pad_next = last_row ? AFTER_ROWS : S_LPAD;
            end
            S_BOT:   begin pad_len = ROWPAD_N; pad_next = AFTER_BOT; end
            S_FLUSH: begin pad_len = FLUSH_N;  pad_next = S_DONE; end
            default: begin pad_len = '0;       pad_next = S_IDLE; end
        endcase

        pad_last = (beat_q == pad_len - 32'd1);

        row_end = ((state_q == S_RPAD) && pad_last) ||
                  ((B == 0) && hs && col_last);

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = FIRST_S;
            end
            S_DATA: begin
                if (hs) begin
                    if (col_last) begin
                        col_d = '0;
                        if (B > 0) state_d = S_RPAD;
                        else state_d = last_row ? AFTER_ROWS : ROW_S;
                    end else begin
                        col_d = col_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (pad_last) begin
                    beat_d  = '0;
                    state_d = pad_next;
                end else begin
                    beat_d = beat_q + 32'd1;
                end
            end
        endcase

        if (row_end) row_d = last_row ? '0 : row_q + 32'd1;

        if (start_ok) begin
            out_cnt_d  = '0;
            count_ok_d = 1'b0;
        end else begin
            if (f_ovalid && busy_q) out_cnt_d = out_cnt_q + 32'd1;
            if (state_q == S_DONE) count_ok_d = (out_cnt_q == PIX_TOTAL);
        end
    end

    always_comb begin
        is_pad = (state_q == S_TOP)  || (state_q == S_LPAD) ||
                 (state_q == S_RPAD) || (state_q == S_BOT)  ||
                 (state_q == S_FLUSH);
        s_ready      = (state_q == S_DATA);
        f_valid_d    = is_pad || hs;
        f_data_d     = hs ? s_data : '0;
        frame_done_d = (state_q == S_DONE);
        busy_d       = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    assign busy       = busy_q;
    assign f_valid    = f_valid_q;
    assign f_data     = f_data_q;
    assign frame_done = frame_done_q;
    assign count_ok   = count_ok_q;

endmodule

// File: tb/tb_filter_frame_sequencer.sv
// Bench for filter_frame_sequencer: two configurations, expected beat
// stream kept in a queue and popped as the DUT emits f_valid beats.
module tb_filter_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       start, s_valid, f_ovalid;
    logic [1:0][23:0] s_data;
    logic [1:0]       busy, s_ready, f_valid, frame_done, count_ok;
    logic [1:0][23:0] f_data;

    filter_frame_sequencer #(
        .WIDTH(4), .HEIGHT(3), .KERNEL_SIZE(3), .FLUSH(9)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .f_valid(f_valid[0]), .f_data(f_data[0]), .f_ovalid(f_ovalid[0]),
        .frame_done(frame_done[0]), .count_ok(count_ok[0])
    );

    filter_frame_sequencer #(
        .WIDTH(8), .HEIGHT(2), .KERNEL_SIZE(7), .FLUSH(11)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .f_valid(f_valid[1]), .f_data(f_data[1]), .f_ovalid(f_ovalid[1]),
        .frame_done(frame_done[1]), .count_ok(count_ok[1])
    );

    int compared = 0;
    int mismatched = 0;

    logic [23:0] exp_q[$];
    int pix[2];

    logic        o_fv, o_done, o_busy, o_ok, o_rdy;
    logic [23:0] o_fd;

    task automatic push_frame(input int k, input int w, input int h,
                              input int fl);
        int b, d;
        b = (k - 1) / 2;
        d = w + 2 * b;
        repeat (b * d) exp_q.push_back(24'd0);
        for (int r = 0; r < h; r++) begin
            repeat (b) exp_q.push_back(24'd0);
            for (int c = 0; c < w; c++) exp_q.push_back(24'(r * w + c + 1));
            repeat (b) exp_q.push_back(24'd0);
        end
        repeat (b * d) exp_q.push_back(24'd0);
        repeat (fl) exp_q.push_back(24'd0);
    endtask

    task automatic sample(input int sel);
        @(negedge clk);
        o_fv   = f_valid[sel];
        o_fd   = f_data[sel];
        o_done = frame_done[sel];
        o_busy = busy[sel];
        o_ok   = count_ok[sel];
        o_rdy  = s_ready[sel];
    endtask

    task automatic drive(input int sel, input bit sv, input bit st,
                         input bit ov, input bit rst);
        reset         = rst;
        start[sel]    = st;
        f_ovalid[sel] = ov;
        s_valid[sel]  = sv;
        s_data[sel]   = 24'(pix[sel] + 1);
        if (sv && s_ready[sel] && !rst) pix[sel]++;
    endtask

    // Drives one frame; pops and compares every emitted beat.
    task automatic run_frame(input int sel, input int mode, input int n_ov,
                             input bit spam, input int abort_at,
                             output int beats, output int last_fv,
                             output int done_cyc, output logic ok_at_done,
                             output bit flow_bad);
        bit prev_stall, sv, rst;
        logic [23:0] e;
        beats = 0; last_fv = -1; done_cyc = -1;
        ok_at_done = 1'bx; flow_bad = 0; prev_stall = 0;
        pix[sel] = 0;
        sample(sel);
        drive(sel, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            sample(sel);
            if (c == 0) begin
                compared++;
                if (o_busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL busy_start got %b want 1", o_busy);
                end
            end
            if (prev_stall && o_fv) flow_bad = 1;
            if (!prev_stall && !o_fv && c > 0 && exp_q.size() > 0)
                flow_bad = 1;
            if (o_fv) begin
                beats++;
                last_fv = c;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL extra_beat got %0h want none", o_fd);
                end else begin
                    e = exp_q.pop_front();
                    if (o_fd !== e) begin
                        mismatched++;
                        $display("FAIL f_data beat %0d got %0h want %0h",
                                 beats, o_fd, e);
                    end
                end
            end
            if (o_done) begin
                done_cyc = c;
                ok_at_done = o_ok;
                drive(sel, 1'b0, spam, 1'b0, 1'b0);
                break;
            end
            sv = (mode == 1) ? (c % 2 == 0) : 1'b1;
            prev_stall = !sv && o_rdy;
            rst = (abort_at >= 0) && (pix[sel] == abort_at);
            drive(sel, sv, spam && (c == 10 || c == 30),
                  (c >= 1) && (c <= n_ov), rst);
            if (rst) return;
        end
        if (abort_at < 0 && done_cyc < 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout got no frame_done want frame_done");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = '0; s_valid = '0; f_ovalid = '0; s_data = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({busy[i], s_ready[i], f_valid[i], frame_done[i],
                 count_ok[i], f_data[i]} !== 29'd0) begin
                mismatched++;
                $display("FAIL reset_outputs dut %0d got %b%b%b%b%b %0h want 0",
                         i, busy[i], s_ready[i], f_valid[i], frame_done[i],
                         count_ok[i], f_data[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic check_tail(input string nm, input int beats,
                              input int want, input int last_fv,
                              input int done_cyc);
        compared++;
        if (beats !== want) begin
            mismatched++;
            $display("FAIL %s_beats got %0d want %0d", nm, beats, want);
        end
        compared++;
        if (done_cyc !== last_fv + 1) begin
            mismatched++;
            $display("FAIL %s_done_timing got %0d want %0d",
                     nm, done_cyc, last_fv + 1);
        end
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL %s_missing_beats got %0d left want 0",
                     nm, exp_q.size());
        end
    endtask

    task automatic test_basic();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad;
        exp_q.delete();
        push_frame(3, 4, 3, 9);
        run_frame(0, 0, 0, 1'b0, -1, beats, last_fv, done_cyc, ok, flow_bad);
        check_tail("t1", beats, 39, last_fv, done_cyc);
        compared++;
        if (flow_bad) begin
            mismatched++;
            $display("FAIL t1_gap got gap want none");
        end
        compared++;
        if (ok !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_count_ok got %b want 0", ok);
        end
        sample(0);
        compared++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            mismatched++;
            $display("FAIL t1_after_done got busy=%b done=%b want 0 0",
                     o_busy, o_done);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad;
        exp_q.delete();
        push_frame(3, 4, 3, 9);
        run_frame(0, 1, 0, 1'b0, -1, beats, last_fv, done_cyc, ok, flow_bad);
        check_tail("t2", beats, 39, last_fv, done_cyc);
        compared++;
        if (flow_bad) begin
            mismatched++;
            $display("FAIL t2_stall_flow got bad want valid-only-unstalled");
        end
        sample(0);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_count();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad;
        for (int n = 12; n >= 11; n--) begin
            exp_q.delete();
            push_frame(3, 4, 3, 9);
            run_frame(0, 0, n, 1'b0, -1, beats, last_fv, done_cyc, ok,
                      flow_bad);
            compared++;
            if (ok !== (n == 12)) begin
                mismatched++;
                $display("FAIL t3_count_ok n=%0d got %b want %b",
                         n, ok, n == 12);
            end
            sample(0);
            compared++;
            if (o_ok !== (n == 12)) begin
                mismatched++;
                $display("FAIL t3_count_ok_hold n=%0d got %b want %b",
                         n, o_ok, n == 12);
            end
            drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad, saw_done;
        exp_q.delete();
        push_frame(3, 4, 3, 9);
        run_frame(0, 0, 0, 1'b0, 6, beats, last_fv, done_cyc, ok, flow_bad);
        sample(0);
        compared++;
        if (o_fv !== 1'b0 || o_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL t4_abort got fv=%b busy=%b want 0 0", o_fv, o_busy);
        end
        drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        saw_done = 0;
        for (int c = 0; c < 60; c++) begin
            sample(0);
            if (o_done || o_fv) saw_done = 1;
            drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        compared++;
        if (saw_done) begin
            mismatched++;
            $display("FAIL t4_no_done got activity want none");
        end
        exp_q.delete();
        push_frame(3, 4, 3, 9);
        run_frame(0, 0, 0, 1'b0, -1, beats, last_fv, done_cyc, ok, flow_bad);
        check_tail("t4", beats, 39, last_fv, done_cyc);
        sample(0);
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad, extra;
        exp_q.delete();
        push_frame(3, 4, 3, 9);
        run_frame(0, 0, 0, 1'b1, -1, beats, last_fv, done_cyc, ok, flow_bad);
        check_tail("t5", beats, 39, last_fv, done_cyc);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            sample(0);
            if (o_fv || o_busy) extra = 1;
            drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        compared++;
        if (extra) begin
            mismatched++;
            $display("FAIL t5_second_frame got activity want idle");
        end
    endtask

    task automatic test_k7();
        int beats, last_fv, done_cyc;
        logic ok;
        bit flow_bad;
        exp_q.delete();
        push_frame(7, 8, 2, 11);
        run_frame(1, 0, 0, 1'b0, -1, beats, last_fv, done_cyc, ok, flow_bad);
        check_tail("t6", beats, 123, last_fv, done_cyc);
        compared++;
        if (flow_bad) begin
            mismatched++;
            $display("FAIL t6_gap got gap want none");
        end
        sample(1);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pix[0] = 0;
        pix[1] = 0;
        test_reset();
        test_basic();
        test_stall();
        test_count();
        test_abort();
        test_back_to_back();
        test_k7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
